// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the player/enemy/bullet datapath.
// Tracks lives and level; drives freeze, flash, level reload and end states.
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   shoot_i       start/resume button (level, synchronised)
//   frame_tick_i  one-cycle pulse per video frame
//   hit_i         player struck (pulse)
//   cleared_i     level cleared (pulse)
//   freeze_o      halt motion in the datapath
//   flash_o       player sprite blink enable
//   level_reset_o one-cycle reload of formation and player position
//   lives_o       remaining lives
//   level_o       current level, 0-based
//   game_over_o   high in OVER
//   game_won_o    high in WON
//   state_o       present state code (debug)
module game_sequencer #(
    parameter int unsigned lives_p        = 3,
    parameter int unsigned levels_p       = 4,
    parameter int unsigned hold_frames_p  = 30,
    parameter int unsigned flash_frames_p = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       shoot_i,
    input  logic       frame_tick_i,
    input  logic       hit_i,
    input  logic       cleared_i,
    output logic       freeze_o,
    output logic       flash_o,
    output logic       level_reset_o,
    output logic [3:0] lives_o,
    output logic [3:0] level_o,
    output logic       game_over_o,
    output logic       game_won_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        TITLE = 3'd0,
        PLAY  = 3'd1,
        HIT   = 3'd2,
        CLEAR = 3'd3,
        OVER  = 3'd4,
        WON   = 3'd5
    } state_e;

    localparam logic [3:0] LIVES_INIT = 4'(lives_p);
    localparam logic [3:0] LAST_LEVEL = 4'(levels_p - 1);
    localparam logic [7:0] HOLD_MAX   = 8'(hold_frames_p);
    localparam logic [7:0] FLASH_LAST = 8'(flash_frames_p - 1);

    state_e     state_q, state_d;
    logic [3:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] flash_cnt_q, flash_cnt_d;
    logic       flash_q, flash_d;
    logic       freeze_q, freeze_d;
    logic       level_reset_q, level_reset_d;
    logic       game_over_q, game_over_d;
    logic       game_won_q, game_won_d;
    logic       shoot_q, shoot_d;

    logic press;
    logic ready;

    assign press = shoot_i & ~shoot_q;
    assign ready = (hold_q == HOLD_MAX);

    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        level_d       = level_q;
        hold_d        = hold_q;
        flash_cnt_d   = flash_cnt_q;
        flash_d       = flash_q;
        level_reset_d = 1'b0;
        shoot_d       = shoot_i;

        // Saturating frame count; only meaningful in paused states,
        // where it is zeroed on the entering transition.
        if (frame_tick_i && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 8'd1;
        end

        case (state_q)
            TITLE: begin
                if (press) begin
                    state_d       = PLAY;
                    lives_d       = LIVES_INIT;
                    level_d       = 4'd0;
                    level_reset_d = 1'b1;
                end
            end
            PLAY: begin
                // A hit outranks a clear arriving in the same cycle.
                if (hit_i) begin
                    lives_d     = lives_q - 4'd1;
                    hold_d      = 8'd0;
                    flash_cnt_d = 8'd0;
                    flash_d     = 1'b1;
                    state_d     = (lives_q == 4'd1) ? OVER : HIT;
                end else if (cleared_i) begin
                    hold_d  = 8'd0;
                    state_d = (level_q == LAST_LEVEL) ? WON : CLEAR;
                end
            end
            HIT: begin
                if (frame_tick_i) begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d = 8'd0;
                        flash_d     = ~flash_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 8'd1;
                    end
                end
                // Resume mid-level: no formation reload.
                if (press && ready) begin
                    state_d = PLAY;
                end
            end
            CLEAR: begin
                if (press && ready) begin
                    state_d       = PLAY;
                    level_d       = level_q + 4'd1;
                    level_reset_d = 1'b1;
                end
            end
            OVER: begin
                if (press && ready) begin
                    state_d       = PLAY;
                    lives_d       = LIVES_INIT;
                    level_d       = 4'd0;
                    level_reset_d = 1'b1;
                end
            end
            WON: begin
                state_d = WON;
            end
            default: begin
                state_d = TITLE;
            end
        endcase

        if (state_d != HIT) begin
            flash_d = 1'b0;
        end
        freeze_d    = (state_d != PLAY);
        game_over_d = (state_d == OVER);
        game_won_d  = (state_d == WON);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= TITLE;
            lives_q       <= LIVES_INIT;
            level_q       <= 4'd0;
            hold_q        <= 8'd0;
            flash_cnt_q   <= 8'd0;
            flash_q       <= 1'b0;
            freeze_q      <= 1'b1;
            level_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
            game_won_q    <= 1'b0;
            shoot_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            hold_q        <= hold_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_q       <= flash_d;
            freeze_q      <= freeze_d;
            level_reset_q <= level_reset_d;
            game_over_q   <= game_over_d;
            game_won_q    <= game_won_d;
            shoot_q       <= shoot_d;
        end
    end

    assign freeze_o      = freeze_q;
    assign flash_o       = flash_q;
    assign level_reset_o = level_reset_q;
    assign lives_o       = lives_q;
    assign level_o       = level_q;
    assign game_over_o   = game_over_q;
    assign game_won_o    = game_won_q;
    assign state_o       = state_q;

endmodule
